// File: rtl/seven_seg_bcd_driver.sv
// Binary-to-BCD (double dabble) converter driving DIGITS active-low seven-segment digits.
// Latency: o_done rises IN_W+1 cycles after the capture edge; back-to-back throughput IN_W+2 cycles.
// Backpressure: o_ready is high only in IDLE; requests while busy are dropped, never queued.
module seven_seg_bcd_driver #(
    parameter int IN_W     = 16,
    parameter int DIGITS   = 5,
    parameter int BLANK_LZ = 1,
    parameter int SIGNED   = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [IN_W-1:0]       i_value,
    output logic                  o_ready,
    output logic [7*DIGITS-1:0]   o_seven,
    output logic                  o_done,
    output logic                  o_overflow
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(IN_W - 1);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
    localparam logic [6:0]       SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [IN_W-1:0]      mag_q, mag_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 neg_q, neg_d;
    logic [7*DIGITS-1:0]  seven_q, seven_d;
    logic                 oflow_q, oflow_d;
    logic                 done_q, done_d;

    logic [BCD_W-1:0]     bcd_adj;
    logic [7*DIGITS-1:0]  disp_seven;
    logic                 disp_ovf;
    logic                 lz_seen;
    logic [3:0]           cur_dig;

    // Active-low segment pattern for one decimal digit (bit6..bit0 = g..a).
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1011000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Segment image for the finished conversion: dashes on overflow, sign digit, leading-zero blanking.
    always_comb begin
        disp_ovf   = ovf_q;
        disp_seven = '1;
        lz_seen    = 1'b0;
        cur_dig    = 4'd0;
        // With a sign digit, anything reaching the top BCD digit does not fit the numeric field.
        if (SIGNED != 0 && bcd_q[BCD_W-1 -: 4] != 4'd0) begin
            disp_ovf = 1'b1;
        end
        for (int k = DIGITS - 1; k >= 0; k--) begin
            cur_dig = bcd_q[4*k +: 4];
            if (disp_ovf) begin
                disp_seven[7*k +: 7] = SEG_DASH;
            end else if (SIGNED != 0 && k == DIGITS - 1) begin
                disp_seven[7*k +: 7] = neg_q ? SEG_DASH : SEG_BLANK;
            end else begin
                if (cur_dig != 4'd0) begin
                    lz_seen = 1'b1;
                end
                if (BLANK_LZ != 0 && !lz_seen && k != 0) begin
                    disp_seven[7*k +: 7] = SEG_BLANK;
                end else begin
                    disp_seven[7*k +: 7] = seg_digit(cur_dig);
                end
            end
        end
    end

    // Next-state and datapath: capture in IDLE, IN_W shift steps, publish the result in FINISH.
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        neg_d   = neg_q;
        seven_d = seven_q;
        oflow_d = oflow_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    // Negation is done modulo 2^IN_W so the most negative value yields its true magnitude.
                    neg_d   = (SIGNED != 0) && i_value[IN_W-1];
                    mag_d   = neg_d ? -i_value : i_value;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], mag_q[IN_W-1]};
                mag_d = {mag_q[IN_W-2:0], 1'b0};
                // A bit falling off the top digit means the value does not fit: sticky for this conversion.
                ovf_d = ovf_q | bcd_adj[BCD_W-1];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                seven_d = disp_seven;
                oflow_d = disp_ovf;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset darkens the display and abandons any conversion in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            seven_q <= '1;
            oflow_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
            seven_q <= seven_d;
            oflow_q <= oflow_d;
            done_q  <= done_d;
        end
    end

    assign o_ready    = (state_q == ST_IDLE);
    assign o_seven    = seven_q;
    assign o_done     = done_q;
    assign o_overflow = oflow_q;

endmodule

// File: tb/tb_seven_seg_bcd_driver.sv
// Scoreboard bench for seven_seg_bcd_driver over three parameter sets.
// Latency: expects o_done exactly IN_W+1 cycles after each capture edge.
// Backpressure: drives noise on i_valid while busy; any unexpected o_done is flagged.
`timescale 1ns/1ps
module tb_seven_seg_bcd_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  vld;
    logic [15:0] val0, val1;
    logic [7:0]  val2;
    logic [2:0]  rdy, dn, of;
    logic [34:0] sev0;
    logic [27:0] sev1, sev2;

    int cyc    = 0;
    int checks = 0;
    int passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // u0: defaults; u1: 4 digits, no blanking; u2: 8-bit signed, 4 digits.
    seven_seg_bcd_driver u0 (
        .i_clk(clk), .i_rst(rst), .i_valid(vld[0]), .i_value(val0),
        .o_ready(rdy[0]), .o_seven(sev0), .o_done(dn[0]), .o_overflow(of[0]));
    seven_seg_bcd_driver #(.IN_W(16), .DIGITS(4), .BLANK_LZ(0), .SIGNED(0)) u1 (
        .i_clk(clk), .i_rst(rst), .i_valid(vld[1]), .i_value(val1),
        .o_ready(rdy[1]), .o_seven(sev1), .o_done(dn[1]), .o_overflow(of[1]));
    seven_seg_bcd_driver #(.IN_W(8), .DIGITS(4), .BLANK_LZ(1), .SIGNED(1)) u2 (
        .i_clk(clk), .i_rst(rst), .i_valid(vld[2]), .i_value(val2),
        .o_ready(rdy[2]), .o_seven(sev2), .o_done(dn[2]), .o_overflow(of[2]));

    typedef struct {
        logic [56:0] exp;   // {overflow, segments}
        int          cap;   // cycle index of the capture edge
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int dirv[3][5] = '{'{12345, 0, 7, 65535, 1000},
                       '{9999, 10000, 0, 65535, 42},
                       '{128, 5, 255, 127, 0}};

    function automatic logic [6:0] seg_of(input longint d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1011000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Decimal reference: divide/modulo the magnitude, no knowledge of the shift algorithm.
    function automatic logic [56:0] model(input longint v, input int digits, input bit sgn, input bit blank);
        logic [55:0] s;
        bit          neg, ovf;
        longint      mag, lim, p;
        int          nd;
        s   = '0;
        neg = sgn && (v < 0);
        mag = neg ? -v : v;
        nd  = sgn ? digits - 1 : digits;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        ovf = (mag >= lim);
        p = 1;
        for (int k = 0; k < digits; k++) begin
            if (ovf)                          s[7*k +: 7] = 7'b0111111;
            else if (sgn && k == digits - 1)  s[7*k +: 7] = neg ? 7'b0111111 : 7'b1111111;
            else if (blank && k > 0 && mag < p) s[7*k +: 7] = 7'b1111111;
            else                              s[7*k +: 7] = seg_of((mag / p) % 10);
            p = p * 10;
        end
        return {ovf, s};
    endfunction

    function automatic int in_w(input int idx);
        return (idx == 2) ? 8 : 16;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s dut%0d: actual=%0h required=%0h", nm, idx, act, req);
    endtask

    task automatic set_in(input int idx, input logic b, input logic [15:0] v);
        case (idx)
            0: begin vld[0] = b; val0 = v; end
            1: begin vld[1] = b; val1 = v; end
            default: begin vld[2] = b; val2 = v[7:0]; end
        endcase
    endtask

    task automatic push(input int idx, input logic [15:0] v);
        exp_t      e;
        logic [7:0] v8;
        longint    sv;
        v8    = v[7:0];
        e.cap = cyc + 1;
        case (idx)
            0: begin sv = longint'(v); e.exp = model(sv, 5, 1'b0, 1'b1); q0.push_back(e); end
            1: begin sv = longint'(v); e.exp = model(sv, 4, 1'b0, 1'b0); q1.push_back(e); end
            default: begin sv = $signed(v8); e.exp = model(sv, 4, 1'b1, 1'b1); q2.push_back(e); end
        endcase
    endtask

    task automatic check_done(input int idx, input logic [55:0] s, input logic o, input logic r);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (idx)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            $display("FAIL unexpected_done dut%0d: o_done=1 required=0", idx);
            return;
        end
        chk("segments", idx, 64'(s), 64'(e.exp[55:0]));
        chk("overflow", idx, 64'(o), 64'(e.exp[56]));
        chk("latency", idx, 64'(cyc - e.cap), 64'(in_w(idx) + 1));
        chk("ready_at_done", idx, 64'(r), 64'd1);
    endtask

    // Monitor: pops the scoreboard on every o_done, sampled on the falling edge.
    always @(negedge clk) begin
        if (dn[0]) check_done(0, {21'b0, sev0}, of[0], rdy[0]);
        if (dn[1]) check_done(1, {28'b0, sev1}, of[1], rdy[1]);
        if (dn[2]) check_done(2, {28'b0, sev2}, of[2], rdy[2]);
    end

    task automatic run_seq(input int idx, input int n);
        int         w;
        logic [15:0] v;
        for (int t = 0; t < n; t++) begin
            w = 0;
            while (!rdy[idx] && w < 100) begin
                v = 16'($urandom);
                set_in(idx, ($urandom_range(0, 2) == 0), v);
                @(negedge clk);
                w++;
            end
            if (w >= 100) begin
                checks++;
                $display("FAIL ready_timeout dut%0d: o_ready=0 required=1", idx);
            end
            if (t >= 5 && $urandom_range(0, 1) == 1) begin
                set_in(idx, 1'b0, 16'd0);
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            if (t < 5) v = 16'(dirv[idx][t]);
            else begin
                case (idx)
                    0: v = 16'($urandom);
                    1: v = 16'($urandom_range(0, 12000));
                    default: v = 16'($urandom_range(0, 255));
                endcase
            end
            set_in(idx, 1'b1, v);
            push(idx, v);
            @(negedge clk);
        end
        set_in(idx, 1'b0, 16'd0);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 0, 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        vld  = '0;
        val0 = '0;
        val1 = '0;
        val2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_seven", 0, 64'(sev0), 64'({35{1'b1}}));
        chk("rst_seven", 1, 64'(sev1), 64'({28{1'b1}}));
        chk("rst_seven", 2, 64'(sev2), 64'({28{1'b1}}));
        chk("rst_ready", 0, 64'(rdy), 64'(3'b111));
        chk("rst_done", 0, 64'(dn), 64'(3'b000));
        chk("rst_overflow", 0, 64'(of), 64'(3'b000));
        rst = 1'b0;
        @(negedge clk);

        run_seq(0, 30);
        run_seq(1, 30);
        run_seq(2, 30);
        drain();

        // Abort a conversion mid-shift; i_valid on the reset edge must be ignored too.
        set_in(0, 1'b1, 16'd12345);
        @(negedge clk);
        set_in(0, 1'b0, 16'd0);
        repeat (8) @(negedge clk);
        chk("busy_before_abort", 0, 64'(rdy[0]), 64'd0);
        rst = 1'b1;
        set_in(0, 1'b1, 16'd321);
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 1'b0, 16'd0);
        chk("abort_seven", 0, 64'(sev0), 64'({35{1'b1}}));
        chk("abort_ready", 0, 64'(rdy[0]), 64'd1);
        chk("abort_done", 0, 64'(dn[0]), 64'd0);
        chk("abort_overflow", 0, 64'(of[0]), 64'd0);
        repeat (25) @(negedge clk);
        chk("abort_dark_hold", 0, 64'(sev0), 64'({35{1'b1}}));

        run_seq(0, 8);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
